stream_tap_arbiter: RTL and testbench

STREAM_TAP_ARBITER -- requirements
Module: stream_tap_arbiter

---
 rtl/stream_tap_arbiter_if.sv | 43 ++++
 rtl/stream_tap_arbiter.sv | 129 ++++++++++++
 tb/tb_stream_tap_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_tap_arbiter_if.sv
// Channel-tap requester bundle and muxed output stream.
// slave: arbiter side; master: taps plus downstream sink.
interface stream_tap_arbiter_if #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_in_progress;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_ready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic [2:0]                    m_axis_tid;
  logic                          m_axis_tready;

  modport slave (
    input  src_valid,
    input  src_in_progress,
    input  src_last,
    input  src_data,
    input  m_axis_tready,
    output src_ready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tid
  );

  modport master (
    output src_valid,
    output src_in_progress,
    output src_last,
    output src_data,
    output m_axis_tready,
    input  src_ready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tid
  );
endinterface

// File: rtl/stream_tap_arbiter.sv
// Round-robin packet arbiter merging channel taps into one stream.
// Grants are held per packet and force-released after idle timeout.
module stream_tap_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  stream_tap_arbiter_if.slave   bus,
  output logic [31:0]           pkt_count,
  output logic [15:0]           timeout_count
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [IW:0] NS = (IW+1)'(NUM_SRC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);
  localparam logic [16:0] TO_L = 17'(TIMEOUT);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   r_rr_ptr;
  logic [15:0]     r_idle_cnt;
  logic [31:0]     r_pkt_count;
  logic [15:0]     r_to_count;

  logic [DATA_WIDTH-1:0] w_data [NUM_SRC];
  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [IW:0]     w_sum;
  logic [IW-1:0]   w_idx;
  logic            w_locked;
  logic            w_hs;
  logic            w_last_hs;
  logic            w_busy;
  logic [IW-1:0]   w_next_ptr;
  logic [16:0]     w_idle_nxt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_data[g] = bus.src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= NS) w_sum = w_sum - NS;
      w_idx = w_sum[IW-1:0];
      if (!w_any && bus.src_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_locked = (r_state == LOCKED);

  always_comb begin
    bus.src_ready     = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tid    = '0;
    if (w_locked) begin
      bus.src_ready[r_gnt] = bus.m_axis_tready;
      bus.m_axis_tvalid    = bus.src_valid[r_gnt];
      bus.m_axis_tlast     = bus.src_last[r_gnt];
      bus.m_axis_tdata     = w_data[r_gnt];
      bus.m_axis_tid       = 3'(r_gnt);
    end
  end

  assign w_hs       = w_locked & bus.m_axis_tvalid & bus.m_axis_tready;
  assign w_last_hs  = w_hs & bus.m_axis_tlast;
  assign w_busy     = bus.src_in_progress[r_gnt] & bus.src_valid[r_gnt];
  assign w_next_ptr = (r_gnt == LAST_IDX) ? '0 : r_gnt + 1'b1;
  assign w_idle_nxt = {1'b0, r_idle_cnt} + 17'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_idle_cnt  <= '0;
      r_pkt_count <= '0;
      r_to_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_idle_cnt <= '0;
          if (w_any) begin
            r_gnt   <= w_pick;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_last_hs) begin
            r_state     <= IDLE;
            r_rr_ptr    <= w_next_ptr;
            r_pkt_count <= r_pkt_count + 32'd1;
            r_idle_cnt  <= '0;
          end else if (w_hs || w_busy) begin
            r_idle_cnt <= '0;
          end else if (w_idle_nxt == TO_L) begin
            r_state    <= IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_idle_cnt <= '0;
            if (r_to_count != 16'hFFFF)
              r_to_count <= r_to_count + 16'd1;
          end else begin
            r_idle_cnt <= w_idle_nxt[15:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pkt_count     = r_pkt_count;
  assign timeout_count = r_to_count;
endmodule

// File: tb/tb_stream_tap_arbiter.sv
// Directed and random checks of stream_tap_arbiter against a
// packet-level reference model.
module tb_stream_tap_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  stream_tap_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus();
  logic [31:0] pkt_count;
  logic [15:0] timeout_count;

  stream_tap_arbiter #(
    .NUM_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .pkt_count(pkt_count),
    .timeout_count(timeout_count)
  );

  logic [DW-1:0] sd [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.src_data[g*DW +: DW] = sd[g];
  end

  int vecs = 0;
  int errs = 0;

  bit          m_locked;
  logic [2:0]  m_gnt;
  int          m_rr;
  int          m_idle;
  logic [31:0] m_pkt;
  logic [15:0] m_to;
  bit          m_hs;
  bit          rec;
  logic [2:0]  q_tid [$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_gnt    = '0;
    m_rr     = 0;
    m_idle   = 0;
    m_pkt    = '0;
    m_to     = '0;
    m_hs     = 1'b0;
  endtask

  task automatic check_outs(string tag);
    logic [N-1:0]  e_rdy;
    logic          e_v;
    logic          e_l;
    logic [DW-1:0] e_d;
    logic [2:0]    e_id;
    e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0; e_id = '0;
    if (m_locked) begin
      e_rdy[m_gnt] = bus.m_axis_tready;
      e_v  = bus.src_valid[m_gnt];
      e_l  = bus.src_last[m_gnt];
      e_d  = sd[m_gnt];
      e_id = m_gnt;
    end
    if (rec && bus.m_axis_tvalid) q_tid.push_back(bus.m_axis_tid);
    chk({tag, ".ready"}, 64'(bus.src_ready), 64'(e_rdy));
    chk({tag, ".tvalid"}, 64'(bus.m_axis_tvalid), 64'(e_v));
    chk({tag, ".tlast"}, 64'(bus.m_axis_tlast), 64'(e_l));
    chk({tag, ".tdata"}, 64'(bus.m_axis_tdata), 64'(e_d));
    chk({tag, ".tid"}, 64'(bus.m_axis_tid), 64'(e_id));
    chk({tag, ".pkt"}, 64'(pkt_count), 64'(m_pkt));
    chk({tag, ".tocnt"}, 64'(timeout_count), 64'(m_to));
  endtask

  // check current cycle, then advance model across the clock edge
  task automatic step(string tag);
    #2;
    check_outs(tag);
    @(posedge clk);
    m_hs = 1'b0;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        logic [2:0] c;
        c = 3'((m_rr + k) % N);
        if (bus.src_valid[c]) begin
          m_gnt    = c;
          m_locked = 1'b1;
          m_idle   = 0;
          break;
        end
      end
    end else begin
      m_hs = bus.src_valid[m_gnt] && bus.m_axis_tready;
      if (m_hs && bus.src_last[m_gnt]) begin
        m_locked = 1'b0;
        m_rr     = (int'(m_gnt) + 1) % N;
        m_pkt    = m_pkt + 32'd1;
        m_idle   = 0;
      end else if (m_hs ||
                   (bus.src_in_progress[m_gnt] && bus.src_valid[m_gnt])) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_locked = 1'b0;
          m_rr     = (int'(m_gnt) + 1) % N;
          m_idle   = 0;
          if (m_to != 16'hFFFF) m_to = m_to + 16'd1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.src_valid       = '0;
    bus.src_in_progress = '0;
    bus.src_last        = '0;
    bus.m_axis_tready   = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    check_outs("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic burst(logic [2:0] s, int beats, output int cyc);
    int b;
    b = 0;
    cyc = 0;
    bus.src_valid[s]       = 1'b1;
    bus.src_in_progress[s] = 1'b1;
    sd[s] = $urandom;
    bus.src_last[s] = (beats == 1);
    while (b < beats && cyc < 50) begin
      step("burst");
      cyc++;
      if (m_hs) begin
        b++;
        sd[s] = $urandom;
        bus.src_last[s] = (b == beats - 1);
      end
    end
    chk("burst.beats", 64'(b), 64'(beats));
    bus.src_valid[s]       = 1'b0;
    bus.src_in_progress[s] = 1'b0;
    bus.src_last[s]        = 1'b0;
  endtask

  initial begin
    int c;
    logic [DW-1:0] held;
    logic [2:0] exp_tid [6];
    exp_tid = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    rec = 1'b0;
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    clear_inputs();
    model_reset();
    #3;
    check_outs("por");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // single 3-beat burst on source 2
    bus.m_axis_tready = 1'b1;
    burst(3'd2, 3, c);
    chk("t1.cycles", 64'(c), 64'd4);
    step("t1.idle");
    chk("t1.pkt", 64'(pkt_count), 64'd1);

    // all sources requesting single-beat packets
    do_reset();
    bus.src_valid     = 5'b11111;
    bus.src_last      = 5'b11111;
    bus.m_axis_tready = 1'b1;
    rec = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < N; j++) sd[j] = $urandom;
      step("t2");
    end
    rec = 1'b0;
    chk("t2.ngrants", 64'(q_tid.size()), 64'd6);
    for (int i = 0; i < 6 && i < q_tid.size(); i++)
      chk("t2.order", 64'(q_tid[i]), 64'(exp_tid[i]));

    // backpressure mid-burst while the tap stays in progress
    do_reset();
    bus.src_valid[3]       = 1'b1;
    bus.src_in_progress[3] = 1'b1;
    bus.m_axis_tready      = 1'b1;
    sd[3] = $urandom;
    step("t3.arb");
    step("t3.b1");
    held = $urandom;
    sd[3] = held;
    bus.m_axis_tready = 1'b0;
    repeat (10) begin
      step("t3.hold");
      chk("t3.stable", 64'(bus.m_axis_tdata), 64'(held));
    end
    bus.m_axis_tready = 1'b1;
    step("t3.b2");
    sd[3] = $urandom;
    step("t3.b3");
    sd[3] = $urandom;
    bus.src_last[3] = 1'b1;
    step("t3.b4");
    clear_inputs();
    step("t3.idle");
    chk("t3.tocnt", 64'(timeout_count), 64'd0);
    chk("t3.pkt", 64'(pkt_count), 64'd1);

    // grant abandoned by source 1 times out
    do_reset();
    bus.src_valid[1]       = 1'b1;
    bus.src_in_progress[1] = 1'b1;
    step("t4.arb");
    bus.src_valid[1]       = 1'b0;
    bus.src_in_progress[1] = 1'b0;
    repeat (3) step("t4.wait");
    #1;
    chk("t4.tocnt3", 64'(timeout_count), 64'd0);
    step("t4.wait");
    #1;
    chk("t4.tocnt4", 64'(timeout_count), 64'd1);
    bus.src_valid = 5'b11111;
    step("t4.rearb");
    #1;
    chk("t4.rrptr", 64'(bus.m_axis_tid), 64'd2);
    step("t4.locked");

    // asynchronous reset on beat 2 of a 4-beat burst
    do_reset();
    bus.m_axis_tready = 1'b1;
    burst(3'd0, 1, c);
    bus.src_valid[3]       = 1'b1;
    bus.src_in_progress[3] = 1'b1;
    sd[3] = $urandom;
    step("t5.arb");
    sd[3] = $urandom;
    step("t5.b1");
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outs("t5.rst");
    chk("t5.pkt", 64'(pkt_count), 64'd0);
    chk("t5.tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.src_valid       = 5'b01010;
    bus.src_in_progress = 5'b00000;
    bus.src_last        = 5'b01010;
    step("t5.arb2");
    #1;
    chk("t5.lowest", 64'(bus.m_axis_tid), 64'd1);
    step("t5.hs");

    // random traffic against the model
    do_reset();
    repeat (400) begin
      bus.src_valid       = N'($urandom);
      bus.src_in_progress = N'($urandom);
      bus.src_last        = N'($urandom) & N'($urandom);
      bus.m_axis_tready   = ($urandom_range(3) != 0);
      for (int j = 0; j < N; j++) sd[j] = $urandom;
      step("rnd");
    end
    #2;
    check_outs("end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
